// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: Tuse/Tnew timing fields, MDU latencies, timer state.
// Helper functions keep the per-operand hazard test and the latency choice in one place.
package hazard_pkg;

    typedef logic [1:0] tuse_t;
    typedef logic [1:0] tnew_t;
    typedef logic [4:0] reg_idx_t;

    localparam tuse_t    TUSE_UNUSED = 2'd3;
    localparam reg_idx_t REG_ZERO    = 5'd0;
    localparam logic [3:0] MULT_LAT  = 4'd5;
    localparam logic [3:0] DIV_LAT   = 4'd10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // A producer stalls a consumer only when its result arrives later than the consumer needs it.
    function automatic logic raw_hazard(input reg_idx_t src, input tuse_t tuse,
                                        input reg_idx_t a3, input tnew_t tnew);
        return (src != REG_ZERO) && (src == a3) && (tuse != TUSE_UNUSED) && (tnew > tuse);
    endfunction

    function automatic logic [3:0] md_lat(input logic is_div);
        return is_div ? DIV_LAT : MULT_LAT;
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: busy for 5 (mult) or 10 (div) cycles after an accepted start.
// Starts during a run are ignored; a flush request cancels only a start in the same cycle.
module md_busy_timer
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic md_start_i,
    input  logic md_div_i,
    input  logic req_i,
    output logic md_busy_o
);

    md_state_e  state_q;
    logic [3:0] cnt_q;
    logic       busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_start_i && !req_i) begin
                        state_q <= MD_RUN;
                        cnt_q   <= md_lat(md_div_i);
                        busy_q  <= 1'b1;
                    end
                end
                MD_RUN: begin
                    // An in-flight operation runs to completion even across a flush.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign md_busy_o = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: combinational data/MDU/EPC stall with zero latency, flush overrides stall.
// Optional stall-cycle counter on stall_cnt when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] E_A3,
    input  logic [4:0] M_A3,
    input  logic [1:0] E_Tnew,
    input  logic [1:0] M_Tnew,
    input  logic       D_md_use,
    input  logic       E_md_start,
    input  logic       E_md_div,
    input  logic       D_eret,
    input  logic       E_mtc0_epc,
    input  logic       M_mtc0_epc,
    input  logic       Req,
    output logic       F_WE,
    output logic       D_WE,
    output logic       E_clr,
    output logic       md_busy,
    output logic       stall
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    logic data_stall;
    logic md_stall;
    logic epc_stall;

    md_busy_timer u_md_busy_timer (
        .clk        (clk),
        .reset      (reset),
        .md_start_i (E_md_start),
        .md_div_i   (E_md_div),
        .req_i      (Req),
        .md_busy_o  (md_busy)
    );

    assign data_stall = raw_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew)
                      | raw_hazard(D_rs, D_Tuse_rs, M_A3, M_Tnew)
                      | raw_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew)
                      | raw_hazard(D_rt, D_Tuse_rt, M_A3, M_Tnew);

    assign md_stall  = D_md_use & (md_busy | E_md_start);
    assign epc_stall = D_eret & (E_mtc0_epc | M_mtc0_epc);

    // Reset is folded in so the front end keeps writing while reset is held.
    assign stall = reset & ~Req & (data_stall | md_stall | epc_stall);
    assign F_WE  = ~stall;
    assign D_WE  = ~stall;
    assign E_clr = stall;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stall causes, flush gating, MDU timer, reset, optional counter.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_A3, M_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic       D_md_use, E_md_start, E_md_div, D_eret, E_mtc0_epc, M_mtc0_epc, Req;
    logic       F_WE, D_WE, E_clr, md_busy, stall;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .E_A3       (E_A3),
        .M_A3       (M_A3),
        .E_Tnew     (E_Tnew),
        .M_Tnew     (M_Tnew),
        .D_md_use   (D_md_use),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .D_eret     (D_eret),
        .E_mtc0_epc (E_mtc0_epc),
        .M_mtc0_epc (M_mtc0_epc),
        .Req        (Req),
        .F_WE       (F_WE),
        .D_WE       (D_WE),
        .E_clr      (E_clr),
        .md_busy    (md_busy),
        .stall      (stall)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        D_rs = 5'd0; D_rt = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
        E_A3 = 5'd0; M_A3 = 5'd0; E_Tnew = 2'd0; M_Tnew = 2'd0;
        D_md_use = 1'b0; E_md_start = 1'b0; E_md_div = 1'b0;
        D_eret = 1'b0; E_mtc0_epc = 1'b0; M_mtc0_epc = 1'b0; Req = 1'b0;
    endtask

    task automatic chk_front(input string tag, input logic exp_stall);
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
        chk({tag, "_fwe"},   {31'd0, F_WE},  {31'd0, ~exp_stall});
        chk({tag, "_dwe"},   {31'd0, D_WE},  {31'd0, ~exp_stall});
        chk({tag, "_eclr"},  {31'd0, E_clr}, {31'd0, exp_stall});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;

        // Reset holds the front end open even with a load-use hazard present.
        E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd1;
        #2;
        chk_front("rst", 1'b0);
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
`ifdef HAZARD_CTRL_PERF_EN
        chk("rst_cnt", stall_cnt, 32'd0);
`endif
        tick(); tick();
        reset = 1'b1;
        #1;
        chk_front("lw_use", 1'b1);
        D_rs = 5'd0;
        #1;
        chk_front("rs_zero", 1'b0);

        // M-stage producer on rt, then timing boundaries.
        idle_inputs();
        M_A3 = 5'd9; M_Tnew = 2'd1; D_rt = 5'd9; D_Tuse_rt = 2'd0;
        #1; chk("m_rt", {31'd0, stall}, 32'd1);
        D_Tuse_rt = 2'd1;
        #1; chk("m_rt_eq", {31'd0, stall}, 32'd0);
        idle_inputs();
        E_A3 = 5'd4; E_Tnew = 2'd3; D_rt = 5'd4; D_Tuse_rt = 2'd3;
        #1; chk("unused", {31'd0, stall}, 32'd0);
        D_Tuse_rt = 2'd2;
        #1; chk("e_rt", {31'd0, stall}, 32'd1);
        D_rt = 5'd5;
        #1; chk("e_rt_diff", {31'd0, stall}, 32'd0);

        // Divide: busy cycles 1..10, D_md_use stalls cycles 0..10.
        idle_inputs();
        tick();
        E_md_start = 1'b1; E_md_div = 1'b1; D_md_use = 1'b1;
        #1;
        chk("div_c0_stall", {31'd0, stall}, 32'd1);
        chk("div_c0_busy", {31'd0, md_busy}, 32'd0);
        tick();
        E_md_start = 1'b0; E_md_div = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            chk($sformatf("div_c%0d_busy", k), {31'd0, md_busy}, 32'd1);
            chk($sformatf("div_c%0d_stall", k), {31'd0, stall}, 32'd1);
            tick();
        end
        #1;
        chk("div_c11_busy", {31'd0, md_busy}, 32'd0);
        chk("div_c11_stall", {31'd0, stall}, 32'd0);

        // Flush cancels a same-cycle start and masks stalls.
        idle_inputs();
        E_md_start = 1'b1; Req = 1'b1;
        tick();
        E_md_start = 1'b0;
        #1; chk("req_start_busy", {31'd0, md_busy}, 32'd0);
        tick();
        #1; chk("req_start_busy2", {31'd0, md_busy}, 32'd0);
        E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd1;
        #1; chk_front("req_gate", 1'b0);
        Req = 1'b0;
        #1; chk("req_off", {31'd0, stall}, 32'd1);

        // eret behind an EPC write.
        idle_inputs();
        D_eret = 1'b1; M_mtc0_epc = 1'b1;
        #1; chk("epc_m", {31'd0, stall}, 32'd1);
        tick();
        D_eret = 1'b0; M_mtc0_epc = 1'b0;
        #1; chk("epc_clear", {31'd0, stall}, 32'd0);
        D_eret = 1'b1; E_mtc0_epc = 1'b1;
        #1; chk("epc_e", {31'd0, stall}, 32'd1);

        // Reset during a multiply aborts it immediately.
        idle_inputs();
        tick();
        E_md_start = 1'b1;
        tick();
        E_md_start = 1'b0;
        #1; chk("mul_c1_busy", {31'd0, md_busy}, 32'd1);
        tick();
        reset = 1'b0; D_md_use = 1'b1;
        #1;
        chk("mul_rst_busy", {31'd0, md_busy}, 32'd0);
        chk("mul_rst_stall", {31'd0, stall}, 32'd0);
        tick();
        reset = 1'b1; D_md_use = 1'b0;
        tick();
        #1; chk("mul_after_rst", {31'd0, md_busy}, 32'd0);

        // Seven stalled edges after reset.
        E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd1;
        for (int k = 0; k < 7; k++) tick();
        idle_inputs();
        #1;
`ifdef HAZARD_CTRL_PERF_EN
        chk("stall_cnt7", stall_cnt, 32'd7);
`endif
        chk("post_cnt_stall", {31'd0, stall}, 32'd0);

        // Multiply survives a flush and ignores a start while running.
        tick();
        E_md_start = 1'b1;
        tick();
        E_md_start = 1'b0; Req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 4) begin
                Req = 1'b0; E_md_start = 1'b1; E_md_div = 1'b1;
            end
            if (k == 5) begin
                E_md_start = 1'b0; E_md_div = 1'b0;
            end
            #1;
            chk($sformatf("mul_c%0d_busy", k), {31'd0, md_busy}, 32'd1);
            tick();
        end
        #1;
        chk("mul_c6_busy", {31'd0, md_busy}, 32'd0);
        tick();
        #1;
        chk("mul_c7_busy", {31'd0, md_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
